core_bus_arbiter: RTL and testbench
===================================

// Module: core_bus_arbiter
// PURPOSE
//  Sits directly downstream of the 5-stage core. Merges the core's instruction-fetch
//  request (fetch stage) and data request (memory stage) onto one memory port.
//  - One outstanding transaction at a time.
//  - Registered request buffering.
//  - dbus priority, with a starvation guard for ibus.
//  - Returns read data and a one-cycle data_ok to the requester that issued the transaction.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive dbus grants while i_valid is pending before ibus is forced.
//                   Legal range 1..15.
// PORTS
//  clk        in   1   clock
//  resetn     in   1   synchronous, active-low reset
//  i_valid    in   1   fetch request valid; held until i_addr_ok
//  i_addr     in   32  fetch physical address (word aligned)
//  i_addr_ok  out  1   fetch request accepted this cycle
//  i_data_ok  out  1   one-cycle pulse; i_rdata valid
//  i_rdata    out  32  fetched instruction word
//  d_valid    in   1   data request valid; held until d_addr_ok
//  d_addr     in   32  data physical address
//  d_size     in   3   access size code (MSIZE1/2/4)
//  d_strobe   in   4   byte write enables; 4'b0000 = read
//  d_wdata    in   32  write data
//  d_addr_ok  out  1   data request accepted this cycle
//  d_data_ok  out  1   one-cycle pulse; d_rdata valid (also pulses for writes)
//  d_rdata    out  32  load data
//  m_valid    out  1   memory request valid
//  m_addr     out  32  memory request address
//  m_size     out  3   memory request size
//  m_strobe   out  4   memory request write strobe
//  m_wdata    out  32  memory write data
//  m_ready    in   1   memory accepts request when m_valid & m_ready
//  m_rvalid   in   1   memory response valid; rdata on m_rdata
//  m_rdata    in   32  memory response data
// BEHAVIOUR
//  Reset (resetn=0 at posedge):
//   - State -> IDLE; starvation counter -> 0; owner -> NONE.
//   - All outputs 0 (i_rdata / d_rdata included).
//   - Reset mid-transaction aborts it: m_valid drops next cycle, no data_ok is issued,
//     and any late m_rvalid is ignored.
//  States:
//   - IDLE: grant computed combinationally.
//       - Grant D if d_valid and NOT (i_valid and cnt==STARVE_LIMIT).
//       - Else grant I if i_valid.
//       - The granted *_addr_ok is asserted in the same cycle; the payload is latched into
//         request regs and owner is recorded; next state is REQ.
//       - Ungranted side: addr_ok=0.
//   - REQ: m_valid=1 with the latched payload, stable until m_ready.
//       - m_ready & m_rvalid -> DONE; m_ready only -> RESP.
//   - RESP: m_valid=0; wait for m_rvalid, then -> DONE.
//   - DONE: owner's *_data_ok=1 for exactly this one cycle; *_rdata holds the captured
//     m_rdata until the next response for that owner; next state is IDLE.
//  Ibus payload: m_size=MSIZE4, m_strobe=0, m_wdata=0.
//  Minimum latency: addr_ok at T, m_valid at T+1, data_ok at T+2 (m_ready & m_rvalid at T+1),
//  next addr_ok at T+3.
//  Starvation counter (4-bit):
//   - Increments on a D grant while i_valid=1.
//   - Clears on an I grant, or on a D grant with i_valid=0.
//   - Saturates at STARVE_LIMIT.
//  Simultaneous i_valid & d_valid in IDLE: D wins unless cnt==STARVE_LIMIT.
//  m_rvalid outside REQ/RESP is ignored. m_rdata is captured only when m_rvalid=1.
//  Requesters may change payload after addr_ok. New requests are not accepted outside IDLE.
// TESTING
//  1. Reset: hold resetn=0 for 2 cycles with i_valid=d_valid=1
//     -> all outputs 0; first addr_ok in the cycle after release.
//  2. Lone fetch i_addr=0x1fc00000; memory m_ready=m_rvalid=1, m_rdata=0x24080001
//     -> i_addr_ok@T, m_valid/m_addr@T+1, i_data_ok with i_rdata=0x24080001@T+2;
//     d_data_ok stays 0.
//  3. Simultaneous i_valid and d_valid read 0x00001000
//     -> D granted first; I granted at the next IDLE; data_ok pulses in order D then I.
//  4. Starvation: d_valid held high with i_valid high, STARVE_LIMIT=4
//     -> 4 D grants, then the 5th grant is I; counter returns to 0.
//  5. Delayed memory: m_ready low for 3 cycles, then m_rvalid 5 cycles after acceptance
//     -> m_addr/m_strobe/m_wdata stable while m_ready=0; exactly one d_data_ok.
//  6. Write d_strobe=4'b0011, d_wdata=0xdeadbeef, then reset asserted during RESP
//     -> m_strobe=0011 during REQ; after reset no d_data_ok even if m_rvalid arrives.

Source files
------------

// File: rtl/core_bus_arbiter.sv
// Arbitrates the core's fetch (ibus) and data (dbus) requests onto one memory port.
// Latency: addr_ok at T, m_valid at T+1, data_ok at T+2 at best; one transaction in flight.
// Backpressure: new requests are accepted only in IDLE; m_valid holds until m_ready.
//
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   i_valid/i_addr -> i_addr_ok      fetch request handshake
//   i_data_ok/i_rdata                fetch response (one-cycle pulse)
//   d_valid/d_addr/d_size/d_strobe/d_wdata -> d_addr_ok   data request handshake
//   d_data_ok/d_rdata                data response (one-cycle pulse, also for writes)
//   m_valid/m_addr/m_size/m_strobe/m_wdata, m_ready       memory request channel
//   m_rvalid/m_rdata                 memory response channel
module core_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [3:0]  d_strobe,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [2:0]  m_size,
  output logic [3:0]  m_strobe,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  // Size code for a full 32-bit word access; fetches are always full words.
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

  state_t      state_q,     state_d;
  owner_t      owner_q,     owner_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic        m_valid_q,   m_valid_d;
  logic [31:0] m_addr_q,    m_addr_d;
  logic [2:0]  m_size_q,    m_size_d;
  logic [3:0]  m_strobe_q,  m_strobe_d;
  logic [31:0] m_wdata_q,   m_wdata_d;
  logic        i_data_ok_q, i_data_ok_d;
  logic        d_data_ok_q, d_data_ok_d;
  logic [31:0] i_rdata_q,   i_rdata_d;
  logic [31:0] d_rdata_q,   d_rdata_d;

  logic in_idle;
  logic grant_d;
  logic grant_i;
  logic starved;

  // Grants are combinational so addr_ok lands in the same cycle as the request.
  // Gating with resetn keeps addr_ok low while reset is held.
  assign in_idle = resetn && (state_q == S_IDLE);
  assign starved = i_valid && (cnt_q == LIMIT);
  assign grant_d = in_idle && d_valid && !starved;
  assign grant_i = in_idle && i_valid && !grant_d;

  assign i_addr_ok = grant_i;
  assign d_addr_ok = grant_d;

  assign m_valid   = m_valid_q;
  assign m_addr    = m_addr_q;
  assign m_size    = m_size_q;
  assign m_strobe  = m_strobe_q;
  assign m_wdata   = m_wdata_q;
  assign i_data_ok = i_data_ok_q;
  assign d_data_ok = d_data_ok_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    m_valid_d   = m_valid_q;
    m_addr_d    = m_addr_q;
    m_size_d    = m_size_q;
    m_strobe_d  = m_strobe_q;
    m_wdata_d   = m_wdata_q;
    i_data_ok_d = 1'b0;
    d_data_ok_d = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          state_d    = S_REQ;
          owner_d    = OWN_D;
          m_valid_d  = 1'b1;
          m_addr_d   = d_addr;
          m_size_d   = d_size;
          m_strobe_d = d_strobe;
          m_wdata_d  = d_wdata;
          // Count dbus wins only while a fetch is actually waiting.
          if (i_valid) begin
            cnt_d = (cnt_q >= LIMIT) ? LIMIT : cnt_q + 4'd1;
          end else begin
            cnt_d = 4'd0;
          end
        end else if (grant_i) begin
          state_d    = S_REQ;
          owner_d    = OWN_I;
          m_valid_d  = 1'b1;
          m_addr_d   = i_addr;
          m_size_d   = MSIZE4;
          m_strobe_d = 4'b0000;
          m_wdata_d  = 32'd0;
          cnt_d      = 4'd0;
        end
      end

      S_REQ: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (m_rvalid) begin
            state_d     = S_DONE;
            i_data_ok_d = (owner_q == OWN_I);
            d_data_ok_d = (owner_q == OWN_D);
            if (owner_q == OWN_I) i_rdata_d = m_rdata;
            if (owner_q == OWN_D) d_rdata_d = m_rdata;
          end else begin
            state_d = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (m_rvalid) begin
          state_d     = S_DONE;
          i_data_ok_d = (owner_q == OWN_I);
          d_data_ok_d = (owner_q == OWN_D);
          if (owner_q == OWN_I) i_rdata_d = m_rdata;
          if (owner_q == OWN_D) d_rdata_d = m_rdata;
        end
      end

      S_DONE: begin
        // data_ok was raised on entry; it drops here after exactly one cycle.
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end

      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Synchronous reset also aborts an in-flight transaction: the FSM returns to
  // IDLE, so a late m_rvalid finds no owner and is dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      cnt_q       <= 4'd0;
      m_valid_q   <= 1'b0;
      m_addr_q    <= 32'd0;
      m_size_q    <= 3'd0;
      m_strobe_q  <= 4'd0;
      m_wdata_q   <= 32'd0;
      i_data_ok_q <= 1'b0;
      d_data_ok_q <= 1'b0;
      i_rdata_q   <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      m_valid_q   <= m_valid_d;
      m_addr_q    <= m_addr_d;
      m_size_q    <= m_size_d;
      m_strobe_q  <= m_strobe_d;
      m_wdata_q   <= m_wdata_d;
      i_data_ok_q <= i_data_ok_d;
      d_data_ok_q <= d_data_ok_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: directed requests, scoreboarded responses.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
// The memory model stalls/acks according to ready_delay and rvalid_delay.
module tb_core_bus_arbiter;

  localparam logic [2:0] MSIZE4 = 3'd2;

  logic        clk;
  logic        resetn;
  logic        i_valid, i_addr_ok, i_data_ok;
  logic [31:0] i_addr, i_rdata;
  logic        d_valid, d_addr_ok, d_data_ok;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_size;
  logic [3:0]  d_strobe;
  logic        m_valid, m_ready, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_size;
  logic [3:0]  m_strobe;

  core_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
    .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] wdata;
  } dreq_t;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;

  logic [31:0] i_pend[$];
  dreq_t       d_pend[$];
  exp_t        sb[$];
  bit          grant_log[$];   // 1 = D grant, 0 = I grant

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int i_ok_cyc = -100, d_ok_cyc = -100, mv_cyc = -100, dok_cyc = -100;
  int i_dok_cnt = 0, d_dok_cnt = 0;
  bit i_seen = 0, d_seen = 0;
  logic [31:0] mv_addr;
  logic [3:0]  mv_strobe;
  logic [2:0]  mv_size;

  // Memory model state
  int          ready_delay = 0;
  int          rvalid_delay = 0;
  int          rdy_cnt = 0;
  int          rv_cnt = 0;
  bit          rv_pending = 0;
  logic [31:0] addr_lat;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h1fc0_0000) return 32'h2408_0001;
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_d(input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd,
                        input bit expect_rsp);
    dreq_t r;
    exp_t  e;
    r.addr = a; r.size = MSIZE4; r.strobe = st; r.wdata = wd;
    d_pend.push_back(r);
    if (expect_rsp) begin
      e.is_d = 1'b1; e.data = mem_fn(a);
      sb.push_back(e);
    end
  endtask

  task automatic push_i(input logic [31:0] a);
    exp_t e;
    i_pend.push_back(a);
    e.is_d = 1'b0; e.data = mem_fn(a);
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (!(sb.size() == 0 && i_pend.size() == 0 && d_pend.size() == 0 && !rv_pending)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({nm, " timeout"}, 72'(n >= budget), 72'd0);
    repeat (2) @(negedge clk);
  endtask

  // Requester driver: holds each request until its addr_ok, then scrambles payload.
  always @(posedge clk) begin
    #1;
    if (i_seen && i_pend.size() > 0) void'(i_pend.pop_front());
    if (d_seen && d_pend.size() > 0) void'(d_pend.pop_front());
    if (i_pend.size() > 0) begin
      i_valid = 1'b1; i_addr = i_pend[0];
    end else begin
      i_valid = 1'b0; i_addr = 32'hffff_fff0;
    end
    if (d_pend.size() > 0) begin
      d_valid = 1'b1; d_addr = d_pend[0].addr; d_size = d_pend[0].size;
      d_strobe = d_pend[0].strobe; d_wdata = d_pend[0].wdata;
    end else begin
      d_valid = 1'b0; d_addr = 32'hbad0_bad0; d_size = 3'd7;
      d_strobe = 4'hf; d_wdata = 32'h0bad_f00d;
    end
  end

  // Memory model
  always @(posedge clk) begin
    #1;
    m_ready = 1'b0;
    m_rvalid = 1'b0;
    m_rdata = 32'h5555_aaaa;
    if (rv_pending) begin
      if (rv_cnt == 0) begin
        m_rvalid = 1'b1; m_rdata = mem_fn(addr_lat); rv_pending = 0;
      end else begin
        rv_cnt--;
      end
    end else if (m_valid) begin
      if (rdy_cnt < ready_delay) begin
        rdy_cnt++;
      end else begin
        m_ready = 1'b1; rdy_cnt = 0; addr_lat = m_addr;
        if (rvalid_delay == 0) begin
          m_rvalid = 1'b1; m_rdata = mem_fn(m_addr);
        end else begin
          rv_pending = 1; rv_cnt = rvalid_delay - 1;
        end
      end
    end
  end

  // Monitor / scoreboard
  logic        mv_prev = 1'b0, mr_prev = 1'b0;
  logic [70:0] pay_prev;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    i_seen = i_addr_ok;
    d_seen = d_addr_ok;
    if (i_addr_ok || d_addr_ok) begin
      check("addr_ok exclusive", 72'(i_addr_ok & d_addr_ok), 72'd0);
      if (i_addr_ok) begin i_ok_cyc = cyc; grant_log.push_back(1'b0); end
      if (d_addr_ok) begin d_ok_cyc = cyc; grant_log.push_back(1'b1); end
    end
    if (m_valid && !mv_prev) begin
      mv_cyc = cyc; mv_addr = m_addr; mv_strobe = m_strobe; mv_size = m_size;
    end
    if (m_valid && mv_prev && !mr_prev)
      check("m payload stable", 72'({m_addr, m_size, m_strobe, m_wdata}), 72'(pay_prev));
    if (i_data_ok || d_data_ok) begin
      dok_cyc = cyc;
      if (d_data_ok) d_dok_cnt++; else i_dok_cnt++;
      check("data_ok exclusive", 72'(i_data_ok & d_data_ok), 72'd0);
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected data_ok: got i=%0b d=%0b expected none", i_data_ok, d_data_ok);
      end else begin
        e = sb.pop_front();
        check("data_ok owner", 72'(d_data_ok), 72'(e.is_d));
        check("rdata", 72'(e.is_d ? d_rdata : i_rdata), 72'(e.data));
      end
    end
    mv_prev = m_valid;
    mr_prev = m_ready;
    pay_prev = {m_addr, m_size, m_strobe, m_wdata};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel_cyc;
    int cnt0;
    logic [10:0] got;
    resetn = 1'b0;
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;

    // 1. Reset held with both requests pending
    push_d(32'h0000_2000, 4'b0000, 32'h0, 1'b1);
    push_i(32'h1fc0_0004);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 72'({i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok}),
          72'd0);
    check("reset d_rdata", 72'(d_rdata), 72'd0);
    check("reset m bus", 72'({m_valid, m_addr, m_size, m_strobe}), 72'd0);
    check("reset m_wdata", 72'(m_wdata), 72'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    rel_cyc = cyc;
    wait_idle("t1", 50);
    check("first grant after release", 72'(d_ok_cyc - rel_cyc), 72'd1);

    // 2. Lone fetch, zero-latency memory
    cnt0 = d_dok_cnt;
    push_i(32'h1fc0_0000);
    wait_idle("t2", 50);
    check("t2 m_valid latency", 72'(mv_cyc - i_ok_cyc), 72'd1);
    check("t2 data_ok latency", 72'(dok_cyc - i_ok_cyc), 72'd2);
    check("t2 m_addr", 72'(mv_addr), 72'h1fc0_0000);
    check("t2 ibus size/strobe", 72'({mv_size, mv_strobe}), 72'({MSIZE4, 4'b0000}));
    check("t2 no d_data_ok", 72'(d_dok_cnt - cnt0), 72'd0);
    check("t2 i_rdata held", 72'(i_rdata), 72'h2408_0001);

    // 3. Simultaneous requests: D first, I at the next IDLE
    push_d(32'h0000_1000, 4'b0000, 32'h0, 1'b1);
    push_i(32'h1fc0_0008);
    wait_idle("t3", 50);
    check("t3 next addr_ok at T+3", 72'(i_ok_cyc - d_ok_cyc), 72'd3);

    // 4. Starvation guard: 9 D and 2 I pending together
    grant_log.delete();
    for (int k = 0; k < 4; k++) push_d(32'h3000 + 32'(4 * k), 4'b0000, 32'h0, 1'b1);
    push_i(32'h1fc0_0010);
    for (int k = 4; k < 8; k++) push_d(32'h3000 + 32'(4 * k), 4'b0000, 32'h0, 1'b1);
    push_i(32'h1fc0_0014);
    push_d(32'h3020, 4'b0000, 32'h0, 1'b1);
    // Driver presents all requests from the start, so re-order i_pend pushes do not
    // affect grant order; the scoreboard order above is the expected grant order.
    wait_idle("t4", 300);
    check("t4 grant count", 72'(grant_log.size()), 72'd11);
    got = '0;
    for (int k = 0; k < 11 && k < grant_log.size(); k++) got[10 - k] = grant_log[k];
    check("t4 grant order", 72'(got), 72'(11'b11110111101));

    // 5. Slow memory with a write
    ready_delay = 3; rvalid_delay = 5;
    cnt0 = d_dok_cnt;
    push_d(32'h0000_4000, 4'b1111, 32'hcafe_f00d, 1'b1);
    wait_idle("t5", 100);
    check("t5 one d_data_ok", 72'(d_dok_cnt - cnt0), 72'd1);
    check("t5 m_strobe", 72'(mv_strobe), 72'hf);
    check("t5 data_ok latency", 72'(dok_cyc - mv_cyc), 72'd9);

    // 6. Write aborted by reset during RESP
    ready_delay = 0; rvalid_delay = 6;
    cnt0 = d_dok_cnt;
    push_d(32'h0000_5000, 4'b0011, 32'hdead_beef, 1'b0);
    begin
      int n = 0;
      while (!rv_pending && n < 50) begin @(negedge clk); n++; end
      check("t6 accept timeout", 72'(n >= 50), 72'd0);
    end
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("t6 m_valid after reset", 72'(m_valid), 72'd0);
    check("t6 rdata cleared", 72'({i_rdata, d_rdata}), 72'd0);
    repeat (12) @(negedge clk);
    check("t6 m_strobe in REQ", 72'(mv_strobe), 72'b0011);
    check("t6 no d_data_ok", 72'(d_dok_cnt - cnt0), 72'd0);
    check("t6 d_rdata stays 0", 72'(d_rdata), 72'd0);

    check("scoreboard drained", 72'(sb.size()), 72'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
